adc_scan_scheduler: RTL and testbench

//  Sequences the LTC2308 serial ADC interface: drives its 3-bit channel select once per
//  16-clock conversion frame and attributes each returned 12-bit result to the right channel.

---
 rtl/adc_sched_pkg.sv | 28 ++
 rtl/adc_tag_pipe.sv | 16 +
 rtl/adc_scan_scheduler.sv | 77 +++++++
 tb/tb_adc_scan_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared types, sizes and channel search helper for the ADC scan scheduler
package adc_sched_pkg;
  localparam int N_CH = 8;
  localparam int RES_W = 12;
  localparam int FRAME_CLKS = 16;
  localparam int PIPE_DEP = 2;
  typedef logic [2:0] chan_t;
  typedef struct packed {
    logic valid;
    logic oneshot;
    chan_t ch;
  } adc_tag_t;
  typedef enum logic [1:0] {OS_IDLE, OS_PEND, OS_FLIGHT} os_state_t;
  // first set mask bit strictly after ptr, wrapping; ptr itself is the last candidate
  function automatic chan_t next_chan(input logic [N_CH-1:0] mask, input chan_t ptr);
    chan_t c;
    logic found;
    next_chan = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      c = chan_t'(32'(ptr) + i);
      if (!found && mask[c]) begin
        next_chan = c;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/adc_tag_pipe.sv
// adc_tag_pipe: PIPE_DEP-deep tag shift register advancing once per conversion frame
module adc_tag_pipe
  import adc_sched_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     shift,
  input  adc_tag_t tag_in,
  output adc_tag_t tag_out
);
  adc_tag_t [PIPE_DEP-1:0] stage;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stage <= '0;
    else if (shift) stage <= {stage[PIPE_DEP-2:0], tag_in};
  assign tag_out = stage[PIPE_DEP-1];
endmodule

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: round-robin/one-shot ADC channel sequencer with per-channel result bank
module adc_scan_scheduler
  import adc_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  conv_pulse,
  input  logic [RES_W-1:0]      adc_result,
  output logic [2:0]            chan,
  input  logic [N_CH-1:0]       scan_mask,
  input  logic                  req_valid,
  input  logic [2:0]            req_chan,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [RES_W-1:0]      resp_data,
  output logic                  smp_stb,
  output logic [2:0]            smp_chan,
  output logic [N_CH*RES_W-1:0] bank_data,
  output logic [N_CH-1:0]       bank_valid
);
  os_state_t state, state_nx;
  chan_t pend_ch, rr;
  adc_tag_t issue, ret;
  logic accept;
  assign req_ready = state == OS_IDLE;
  assign accept = req_valid & req_ready;
  adc_tag_pipe u_pipe (
    .clk(clk),
    .reset_n(reset_n),
    .shift(conv_pulse),
    .tag_in(issue),
    .tag_out(ret)
  );
  // a request accepted on the pulse cycle itself is issued on that same pulse
  always_comb begin
    state_nx = state;
    issue = '0;
    if (conv_pulse && (state == OS_PEND || accept)) begin
      issue.valid = 1'b1;
      issue.oneshot = 1'b1;
      issue.ch = state == OS_PEND ? pend_ch : req_chan;
    end else if (conv_pulse && |scan_mask) begin
      issue.valid = 1'b1;
      issue.ch = next_chan(scan_mask, rr);
    end
    if (accept) state_nx = conv_pulse ? OS_FLIGHT : OS_PEND;
    else if (state == OS_PEND && conv_pulse) state_nx = OS_FLIGHT;
    else if (state == OS_FLIGHT && conv_pulse && ret.valid && ret.oneshot) state_nx = OS_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= OS_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      chan <= '0;
      rr <= chan_t'(N_CH - 1);
      pend_ch <= '0;
      smp_stb <= 1'b0;
      smp_chan <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      bank_data <= '0;
      bank_valid <= '0;
    end else begin
      smp_stb <= conv_pulse & ret.valid;
      resp_valid <= conv_pulse & ret.valid & ret.oneshot;
      if (accept) pend_ch <= req_chan;
      if (conv_pulse && issue.valid) chan <= issue.ch;
      if (conv_pulse && issue.valid && !issue.oneshot) rr <= issue.ch;
      if (conv_pulse && ret.valid) smp_chan <= ret.ch;
      if (conv_pulse && ret.valid && ret.oneshot) resp_data <= adc_result;
      if (conv_pulse && ret.valid && !ret.oneshot) begin
        bank_data[32'(ret.ch)*RES_W +: RES_W] <= adc_result;
        bank_valid[ret.ch] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: directed scoreboard bench with a 16-clock frame ADC model
module tb_adc_scan_scheduler;
  logic clk = 1'b0, reset_n = 1'b0, conv_pulse = 1'b0, req_valid = 1'b0;
  logic [11:0] adc_result = '0, resp_data;
  logic [2:0] chan, smp_chan, req_chan = '0;
  logic [7:0] scan_mask = '0, bank_valid;
  logic req_ready, resp_valid, smp_stb;
  logic [95:0] bank_data;
  typedef struct {bit valid; bit oneshot; logic [2:0] ch;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  int m_state = 0, stb_cnt = 0, obs_acc = 0, obs_resp = 0;
  logic [2:0] m_pch = '0, m_rr = 3'd7, m_chan = '0, c_prev = '0;
  logic [95:0] m_bank = '0;
  logic [7:0] m_bv = '0;
  logic [11:0] m_resp = '0;

  adc_scan_scheduler dut (
    .clk(clk), .reset_n(reset_n), .conv_pulse(conv_pulse), .adc_result(adc_result),
    .chan(chan), .scan_mask(scan_mask), .req_valid(req_valid), .req_chan(req_chan),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .smp_stb(smp_stb), .smp_chan(smp_chan), .bank_data(bank_data), .bank_valid(bank_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] f(input logic [2:0] c);
    return 12'h100 + {9'h0, c};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: model predicts the edge, outputs are checked 1 ns after it
  task automatic tick(input bit p);
    bit acc, retire;
    exp_t e, r;
    int k;
    retire = 0;
    r = '{0, 0, 3'd0};
    conv_pulse = p;
    acc = reset_n && req_valid && m_state == 0;
    if (reset_n && req_valid && req_ready) obs_acc++;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      m_state = 0; m_rr = 3'd7; m_chan = '0; m_bank = '0; m_bv = '0; m_resp = '0;
      sb.delete();
    end else if (p) begin
      e = '{0, 0, 3'd0};
      if (m_state == 1 || acc) begin
        e = '{1, 1, (m_state == 1 ? m_pch : req_chan)};
        m_state = 2;
      end else if (scan_mask != 0) begin
        for (int i = 1; i <= 8; i++) begin
          k = (int'(m_rr) + i) % 8;
          if (!e.valid && scan_mask[k]) e = '{1, 0, 3'(k)};
        end
        m_rr = e.ch;
      end
      if (e.valid) m_chan = e.ch;
      sb.push_back(e);
      if (sb.size() > 2) begin
        r = sb.pop_front();
        retire = r.valid;
      end
      if (retire && r.oneshot) begin
        m_state = 0;
        m_resp = f(r.ch);
      end
      if (retire && !r.oneshot) begin
        m_bank[int'(r.ch)*12 +: 12] = f(r.ch);
        m_bv[r.ch] = 1'b1;
      end
      adc_result = f(c_prev);
      c_prev = chan;
    end else if (acc) begin
      m_state = 1;
      m_pch = req_chan;
    end
    if (smp_stb) stb_cnt++;
    if (resp_valid) obs_resp++;
    chk("req_ready", 96'(req_ready), 96'(m_state == 0));
    chk("chan", 96'(chan), 96'(m_chan));
    chk("smp_stb", 96'(smp_stb), 96'(retire));
    if (retire) chk("smp_chan", 96'(smp_chan), 96'(r.ch));
    chk("resp_valid", 96'(resp_valid), 96'(retire && r.oneshot));
    chk("resp_data", 96'(resp_data), 96'(m_resp));
    if (p) begin
      chk("bank_data", bank_data, m_bank);
      chk("bank_valid", 96'(bank_valid), 96'(m_bv));
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      repeat (15) tick(0);
      tick(1);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick(0);
    reset_n = 1'b1;
  endtask

  initial begin
    // reset values, then full scan
    do_reset(2);
    scan_mask = 8'hFF;
    frames(10);
    chk("t1_bank_valid", 96'(bank_valid), 96'(8'hFF));
    chk("t1_bank_data", bank_data,
        {12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100});
    // sparse mask from a clean bank
    do_reset(3);
    scan_mask = 8'b1000_0100;
    frames(6);
    chk("t2_bank_valid", 96'(bank_valid), 96'(8'h84));
    chk("t2_bank_data", bank_data, (96'(12'h107) << 84) | (96'(12'h102) << 24));
    // one-shot accepted mid-frame
    scan_mask = 8'hFF;
    frames(2);
    repeat (5) tick(0);
    req_chan = 3'd5;
    req_valid = 1'b1;
    tick(0);
    req_valid = 1'b0;
    repeat (9) tick(0);
    tick(1);
    chk("t3_chan", 96'(chan), 96'(3'd5));
    frames(2);
    chk("t3_resp_data", 96'(resp_data), 96'(12'h105));
    // request accepted on the pulse cycle itself
    repeat (15) tick(0);
    req_chan = 3'd6;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    chk("t3b_chan", 96'(chan), 96'(3'd6));
    frames(3);
    chk("t3b_resp_data", 96'(resp_data), 96'(12'h106));
    // empty mask: drain in-flight tags, then silence
    scan_mask = 8'h00;
    frames(2);
    stb_cnt = 0;
    frames(5);
    chk("t4_no_stb", 96'(stb_cnt), 96'(0));
    scan_mask = 8'h01;
    frames(2);
    chk("t4_still_no_stb", 96'(stb_cnt), 96'(0));
    frames(1);
    chk("t4_first_stb", 96'(stb_cnt), 96'(1));
    // reset mid-frame with tags in flight
    scan_mask = 8'hFF;
    frames(3);
    repeat (7) tick(0);
    do_reset(3);
    chk("t5_bank_valid", 96'(bank_valid), 96'(0));
    chk("t5_chan", 96'(chan), 96'(0));
    stb_cnt = 0;
    repeat (5) tick(0);
    tick(1);
    frames(1);
    chk("t5_no_stb", 96'(stb_cnt), 96'(0));
    frames(1);
    chk("t5_stb_after", 96'(stb_cnt), 96'(1));
    // continuous request
    obs_acc = 0;
    obs_resp = 0;
    req_chan = 3'd3;
    req_valid = 1'b1;
    frames(12);
    chk("t6_outstanding", 96'((obs_acc - obs_resp) inside {0, 1}), 96'(1));
    chk("t6_some_resp", 96'(obs_resp >= 3), 96'(1));
    req_valid = 1'b0;
    frames(3);
    chk("t6_balanced", 96'(obs_acc), 96'(obs_resp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
